vga_timing_gen: RTL and testbench
=================================

Name: vga_timing_gen

Overview:
- Raster timing controller for the VGA simulator pipeline, sitting directly upstream of the colour-bar test source.
- Generates the pixel-read strobe and the line/frame markers that the pattern source consumes (o_rd, o_newline, o_newframe).
- Takes the returned packed pixel and drives it to the VGA pins as aligned hsync/vsync/RGB.
- Mode registers are latched only at frame boundaries, so software can retime mid-frame without tearing.

Parameters:
- BITS_PER_COLOR, 4, bits per colour channel; the pixel is 3*BITS_PER_COLOR bits, packed {R,G,B}.
- HW, 12, width of the horizontal counters and mode fields.
- VW, 12, width of the vertical counters and mode fields.
- SYNC_ACTIVE_LOW, 1, 1 means hsync and vsync are driven low while active.

Ports:
- i_pixclk  in  1  pixel clock; the only clock in the block.
- i_reset_n  in  1  reset; asynchronous assert, active-low.
- i_en  in  1  run request.
- i_hm_width/i_hm_porch/i_hm_synch/i_hm_raw  in  HW each  horizontal active / sync-start / sync-end / total.
- i_vm_height/i_vm_porch/i_vm_synch/i_vm_raw  in  VW each  vertical equivalents.
- i_pixel  in  3*BITS_PER_COLOR  pixel from the source, valid the cycle after o_rd.
- o_rd  out  1  pixel request, high for every active pixel.
- o_newline  out  1  one-cycle end-of-line marker.
- o_newframe  out  1  one-cycle end-of-frame marker.
- o_width  out  HW  latched i_hm_width, forwarded to the source.
- o_height  out  VW  latched i_vm_height, forwarded to the source.
- o_hsync, o_vsync  out  1 each  sync outputs.
- o_red, o_grn, o_blu  out  BITS_PER_COLOR each  colour outputs.
- o_err  out  1  latched mode invalid.

Behaviour:
- Reset (i_reset_n low, asynchronous):
  - state=IDLE; hpos=0, vpos=0.
  - o_rd, o_newline, o_newframe and all RGB = 0; o_err = 0.
  - o_hsync/o_vsync inactive; o_width/o_height = 0.
  - All outputs are registered.
- Mode validity: 0 < width <= porch < synch < raw, and the same ordering for the vertical fields.
- States:
  - IDLE: counters held at 0, o_rd=0, syncs inactive, RGB=0. Each cycle the mode inputs are sampled.
    - If i_en is high and the mode is valid: latch the mode, pulse o_newline and o_newframe together for one cycle, go to RUN.
    - If i_en is high and the mode is invalid: o_err=1, stay in IDLE.
  - RUN: hpos counts 0..hraw-1, then wraps.
    - vpos increments on each hpos wrap, counts 0..vraw-1, then wraps.
  - STOP: identical to RUN. At the end of the frame it goes to IDLE instead of wrapping.
- Transitions out of RUN:
  - i_en low in RUN goes to STOP; the frame always completes.
  - i_en high again in STOP returns to RUN, with no glitch.
- o_rd (registered from the counters): high exactly when hpos < width and vpos < height.
- o_newline: high on the cycle where hpos == hraw-1. It never coincides with o_rd.
- o_newframe: high on the cycle where hpos == hraw-1 and vpos == vraw-1. o_newline is also high on that cycle.
- Mode relatch: at each newframe the mode inputs are re-sampled.
  - If valid, they take effect from pixel (0,0) of the next frame, and o_err clears.
  - If invalid, the old mode is kept, o_err=1, and running continues.
- Source timing: the source registers its pixel on o_rd, so i_pixel is valid at cycle N+1 for an o_rd at cycle N.
- Output alignment:
  - At N+2, RGB = i_pixel when the rd delayed by one cycle is high, otherwise 0 (blanking is forced black).
  - hsync active when porch <= hpos < synch; vsync active when vporch <= vpos < vsynch.
  - Both syncs are delayed by 2 stages so they are cycle-aligned with RGB.
- Width rules: counters are HW/VW bits; compares are unsigned; raw values up to 2^HW-1 are legal.
- Reset mid-frame: immediate return to IDLE values; the next i_en restarts with the dual newline/newframe pulse.

Decomposition:
- Package vga_timing_pkg holds:
  - the state enum (IDLE, RUN, STOP);
  - the packed mode struct (width, porch, synch, raw);
  - a mode_valid function;
  - the pipeline latency constant (2).
- Sub-module vga_axis_timer, instantiated twice (horizontal and vertical).
  - Inputs: step enable, clear, latched mode.
  - Outputs: position, active, sync, last.

Test Plan:
- Small mode H=8/10/12/14, V=4/5/6/7, i_en=1 after reset:
  - o_rd high for 8 cycles per line, 4 lines per frame, 32 strobes per frame.
  - o_newline every 14 cycles; o_newframe every 98 cycles.
- Same mode with i_pixel = o_rd count:
  - RGB equals the value presented 2 cycles after its o_rd.
  - o_hsync is low for exactly cycles 10-11 of each line, aligned with RGB.
- 640x480 mode (640/656/752/800, 480/490/492/525):
  - 420000 cycles per frame; 307200 o_rd strobes per frame.
  - vsync low for 1600 cycles per frame.
- i_en dropped mid-frame at vpos=2:
  - Frame finishes, final o_newframe is seen, then IDLE with syncs inactive.
  - Re-enabling gives a dual newline/newframe pulse.
- i_hm_width changed to 15 (> porch) mid-frame:
  - Old timing is kept; o_err=1 at the next newframe.
  - Restoring width 8 clears o_err at the following newframe.
- i_reset_n pulsed low asynchronously mid-line:
  - All outputs reach their reset values before the next clock edge.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared types for the raster timing block.
// Mode fields are held at MODE_W bits and zero-extended from the axis width.
package vga_timing_pkg;

  localparam int MODE_W   = 16;
  localparam int PIPE_LAT = 2;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP
  } state_t;

  typedef struct packed {
    logic [MODE_W-1:0] width;
    logic [MODE_W-1:0] porch;
    logic [MODE_W-1:0] synch;
    logic [MODE_W-1:0] raw;
  } mode_t;

  function automatic logic mode_valid(input mode_t m);
    return (m.width != '0)
        && (m.width <= m.porch)
        && (m.porch < m.synch)
        && (m.synch < m.raw);
  endfunction

endpackage

// File: rtl/vga_axis_timer.sv
// vga_axis_timer: one raster axis counter with active/sync/last flags.
// Wraps to 0 after raw-1; held at 0 while clr is high.
module vga_axis_timer
  import vga_timing_pkg::*;
#(
  parameter int W = 12
) (
  input  logic         i_pixclk,
  input  logic         i_reset_n,
  input  logic         step,
  input  logic         clr,
  input  mode_t        mode,
  output logic [W-1:0] pos,
  output logic         active,
  output logic         sync,
  output logic         last
);

  logic [MODE_W-1:0] p;

  assign p      = MODE_W'(pos);
  assign active = p < mode.width;
  assign sync   = (p >= mode.porch) && (p < mode.synch);
  assign last   = p == (mode.raw - 1'b1);

  // position counter
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pos <= '0;
    end else if (clr) begin
      pos <= '0;
    end else if (step) begin
      pos <= last ? '0 : pos + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing controller for the VGA pipeline.
// Emits pixel strobes and line/frame markers, aligns returned pixels.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int BITS_PER_COLOR = 4,
  parameter int HW             = 12,
  parameter int VW             = 12,
  parameter bit SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic                        i_pixclk,
  input  logic                        i_reset_n,
  input  logic                        i_en,
  input  logic [HW-1:0]               i_hm_width,
  input  logic [HW-1:0]               i_hm_porch,
  input  logic [HW-1:0]               i_hm_synch,
  input  logic [HW-1:0]               i_hm_raw,
  input  logic [VW-1:0]               i_vm_height,
  input  logic [VW-1:0]               i_vm_porch,
  input  logic [VW-1:0]               i_vm_synch,
  input  logic [VW-1:0]               i_vm_raw,
  input  logic [3*BITS_PER_COLOR-1:0] i_pixel,
  output logic                        o_rd,
  output logic                        o_newline,
  output logic                        o_newframe,
  output logic [HW-1:0]               o_width,
  output logic [VW-1:0]               o_height,
  output logic                        o_hsync,
  output logic                        o_vsync,
  output logic [BITS_PER_COLOR-1:0]   o_red,
  output logic [BITS_PER_COLOR-1:0]   o_grn,
  output logic [BITS_PER_COLOR-1:0]   o_blu,
  output logic                        o_err
);

  localparam logic SYNC_OFF = SYNC_ACTIVE_LOW;

  state_t state, state_nx;
  mode_t  hm_in, vm_in;
  mode_t  hmode, vmode;

  logic          in_ok, run, start, frame_end, sample;
  logic          h_act, h_sync, h_last;
  logic          v_act, v_sync, v_last;
  logic [HW-1:0] hpos;
  logic [VW-1:0] vpos;
  logic          unused_pos;

  logic                rd_d1;
  logic [PIPE_LAT-1:0] hs_q, vs_q;

  assign hm_in = '{
    width: MODE_W'(i_hm_width),
    porch: MODE_W'(i_hm_porch),
    synch: MODE_W'(i_hm_synch),
    raw:   MODE_W'(i_hm_raw)
  };
  assign vm_in = '{
    width: MODE_W'(i_vm_height),
    porch: MODE_W'(i_vm_porch),
    synch: MODE_W'(i_vm_synch),
    raw:   MODE_W'(i_vm_raw)
  };

  assign in_ok     = mode_valid(hm_in) && mode_valid(vm_in);
  assign run       = state != IDLE;
  assign start     = (state == IDLE) && i_en && in_ok;
  assign frame_end = run && h_last && v_last;
  assign sample    = ((state == IDLE) && i_en) || frame_end;

  assign unused_pos = ^{hpos, vpos};

  assign o_width  = hmode.width[HW-1:0];
  assign o_height = vmode.width[VW-1:0];

  vga_axis_timer #(.W(HW)) u_htimer (
    .i_pixclk  (i_pixclk),
    .i_reset_n (i_reset_n),
    .step      (run),
    .clr       (!run),
    .mode      (hmode),
    .pos       (hpos),
    .active    (h_act),
    .sync      (h_sync),
    .last      (h_last)
  );

  vga_axis_timer #(.W(VW)) u_vtimer (
    .i_pixclk  (i_pixclk),
    .i_reset_n (i_reset_n),
    .step      (run && h_last),
    .clr       (!run),
    .mode      (vmode),
    .pos       (vpos),
    .active    (v_act),
    .sync      (v_sync),
    .last      (v_last)
  );

  // state register
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // run/stop sequencing; a stop always lets the frame finish
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = RUN;
      RUN: begin
        if (!i_en) state_nx = frame_end ? IDLE : STOP;
      end
      STOP: begin
        if (i_en) state_nx = RUN;
        else if (frame_end) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // mode latch only at frame boundaries; a bad mode keeps the old one
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      hmode <= '0;
      vmode <= '0;
      o_err <= 1'b0;
    end else if (sample) begin
      if (in_ok) begin
        hmode <= hm_in;
        vmode <= vm_in;
        o_err <= 1'b0;
      end else begin
        o_err <= 1'b1;
      end
    end
  end

  // strobes, markers, and sync/RGB alignment pipeline
  always_ff @(posedge i_pixclk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_rd       <= 1'b0;
      o_newline  <= 1'b0;
      o_newframe <= 1'b0;
      rd_d1      <= 1'b0;
      hs_q       <= '0;
      vs_q       <= '0;
      o_hsync    <= SYNC_OFF;
      o_vsync    <= SYNC_OFF;
      o_red      <= '0;
      o_grn      <= '0;
      o_blu      <= '0;
    end else begin
      o_rd       <= run && h_act && v_act;
      o_newline  <= start || (run && h_last);
      o_newframe <= start || frame_end;
      rd_d1      <= o_rd;
      hs_q       <= {hs_q[PIPE_LAT-2:0], run && h_sync};
      vs_q       <= {vs_q[PIPE_LAT-2:0], run && v_sync};
      o_hsync    <= hs_q[PIPE_LAT-1] ? ~SYNC_OFF : SYNC_OFF;
      o_vsync    <= vs_q[PIPE_LAT-1] ? ~SYNC_OFF : SYNC_OFF;
      {o_red, o_grn, o_blu} <= rd_d1 ? i_pixel : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized self-checking bench for vga_timing_gen.
// Expected outputs come from an enumerated raster-position model.
module tb_vga_timing_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [11:0] hw = '0, hp = '0, hs = '0, hr = '0;
  logic [11:0] vw = '0, vp = '0, vs = '0, vr = '0;
  logic [11:0] pixel = '0;
  logic        rd, nl, nf, hsync, vsync, err;
  logic [11:0] width, height;
  logic [3:0]  r, g, b;

  always #5 clk = ~clk;

  vga_timing_gen #(
    .BITS_PER_COLOR (4),
    .HW             (12),
    .VW             (12),
    .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .i_pixclk   (clk),
    .i_reset_n  (rst_n),
    .i_en       (en),
    .i_hm_width (hw),
    .i_hm_porch (hp),
    .i_hm_synch (hs),
    .i_hm_raw   (hr),
    .i_vm_height(vw),
    .i_vm_porch (vp),
    .i_vm_synch (vs),
    .i_vm_raw   (vr),
    .i_pixel    (pixel),
    .o_rd       (rd),
    .o_newline  (nl),
    .o_newframe (nf),
    .o_width    (width),
    .o_height   (height),
    .o_hsync    (hsync),
    .o_vsync    (vsync),
    .o_red      (r),
    .o_grn      (g),
    .o_blu      (b),
    .o_err      (err)
  );

  typedef struct {
    int w;
    int p;
    int s;
    int r;
  } m_t;

  typedef struct {
    int h;
    int v;
    m_t hm;
    m_t vm;
  } pos_t;

  pos_t        ex[$];
  logic [11:0] pix[$];
  int          errors = 0;
  int          checks = 0;
  int          err_lo = 0;
  int          err_hi = 0;

  m_t sm_h = '{8, 10, 12, 14};
  m_t sm_v = '{4, 5, 6, 7};

  // ---------------- reference model ----------------
  function automatic void add_frame(m_t hm, m_t vm, int nlines);
    for (int v = 0; v < nlines; v++) begin
      for (int h = 0; h < hm.r; h++) begin
        pos_t q;
        q.h = h;
        q.v = v;
        q.hm = hm;
        q.vm = vm;
        ex.push_back(q);
      end
    end
  endfunction

  function automatic logic m_rd(int j);
    int c = j - 1;
    if (c < 0 || c >= ex.size()) return 1'b0;
    return ex[c].h < ex[c].hm.w && ex[c].v < ex[c].vm.w;
  endfunction

  function automatic logic m_nl(int j);
    int c = j - 1;
    if (j == 0) return 1'b1;
    if (c >= ex.size()) return 1'b0;
    return ex[c].h == ex[c].hm.r - 1;
  endfunction

  function automatic logic m_nf(int j);
    int c = j - 1;
    if (j == 0) return 1'b1;
    if (c >= ex.size()) return 1'b0;
    return ex[c].h == ex[c].hm.r - 1 && ex[c].v == ex[c].vm.r - 1;
  endfunction

  function automatic logic m_hs(int j);
    int c = j - 3;
    if (c < 0 || c >= ex.size()) return 1'b1;
    return !(ex[c].h >= ex[c].hm.p && ex[c].h < ex[c].hm.s);
  endfunction

  function automatic logic m_vs(int j);
    int c = j - 3;
    if (c < 0 || c >= ex.size()) return 1'b1;
    return !(ex[c].v >= ex[c].vm.p && ex[c].v < ex[c].vm.s);
  endfunction

  function automatic logic [17:0] exp_vec(int j);
    logic [11:0] rgb = '0;
    logic        e;
    if (j >= 2 && m_rd(j - 2)) rgb = pix[j-1];
    e = (j >= err_lo) && (j < err_hi);
    return {m_rd(j), m_nl(j), m_nf(j), m_hs(j), m_vs(j), e, rgb};
  endfunction

  function automatic logic [17:0] obs();
    return {rd, nl, nf, hsync, vsync, err, r, g, b};
  endfunction

  function automatic m_t rnd_mode(int wmax);
    m_t m;
    m.w = int'($urandom_range(wmax, 1));
    m.p = m.w + int'($urandom_range(2, 0));
    m.s = m.p + int'($urandom_range(3, 1));
    m.r = m.s + int'($urandom_range(3, 1));
    return m;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic set_mode(m_t hm, m_t vm);
    hw = 12'(hm.w); hp = 12'(hm.p); hs = 12'(hm.s); hr = 12'(hm.r);
    vw = 12'(vm.w); vp = 12'(vm.p); vs = 12'(vm.s); vr = 12'(vm.r);
  endtask

  task automatic drive_pixel();
    pixel = 12'($urandom);
    pix.push_back(pixel);
  endtask

  task automatic do_reset();
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_run(m_t hm, m_t vm);
    do_reset();
    set_mode(hm, vm);
    en = 1'b1;
    ex.delete();
    pix.delete();
    err_lo = 0;
    err_hi = 0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({rd, nl, nf, err} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_strobes got=%b want=0000", {rd, nl, nf, err});
    end
    checks++;
    if ({hsync, vsync} !== 2'b11) begin
      errors++;
      $display("FAIL reset_syncs got=%b want=11", {hsync, vsync});
    end
    checks++;
    if ({r, g, b, width, height} !== 36'h0) begin
      errors++;
      $display("FAIL reset_data got=%h want=0", {r, g, b, width, height});
    end
    rst_n = 1'b1;
    set_mode(sm_h, sm_v);
    repeat (4) @(negedge clk);
    checks++;
    if ({rd, nl, nf, hsync, vsync} !== 5'b00011) begin
      errors++;
      $display("FAIL idle_no_en got=%b want=00011", {rd, nl, nf, hsync, vsync});
    end
  endtask

  task automatic test_small_raster();
    int nrd = 0;
    int nnl = 0;
    start_run(sm_h, sm_v);
    add_frame(sm_h, sm_v, 7);
    add_frame(sm_h, sm_v, 7);
    for (int j = 0; j <= 196; j++) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_vec(j)) begin
        errors++;
        if (errors < 30) $display("FAIL small j=%0d got=%h want=%h", j, obs(), exp_vec(j));
      end
      if (j >= 1 && j <= 98) begin
        nrd += int'(rd);
        nnl += int'(nl);
      end
      drive_pixel();
    end
    checks++;
    if (nrd != 32) begin
      errors++;
      $display("FAIL small_rd_count got=%0d want=32", nrd);
    end
    checks++;
    if (nnl != 7) begin
      errors++;
      $display("FAIL small_nl_count got=%0d want=7", nnl);
    end
    checks++;
    if (width !== 12'd8 || height !== 12'd4) begin
      errors++;
      $display("FAIL small_wh got=%0d/%0d want=8/4", width, height);
    end
  endtask

  task automatic test_vga640();
    m_t h = '{640, 656, 752, 800};
    m_t v = '{480, 490, 492, 525};
    start_run(h, v);
    add_frame(h, v, 3);
    for (int j = 0; j <= 2400; j++) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_vec(j)) begin
        errors++;
        if (errors < 30) $display("FAIL vga640 j=%0d got=%h want=%h", j, obs(), exp_vec(j));
      end
      drive_pixel();
    end
    checks++;
    if (width !== 12'd640 || height !== 12'd480) begin
      errors++;
      $display("FAIL vga640_wh got=%0d/%0d want=640/480", width, height);
    end
  endtask

  task automatic test_wide();
    m_t h = '{4000, 4050, 4090, 4095};
    m_t v = '{2, 3, 4, 5};
    start_run(h, v);
    add_frame(h, v, 5);
    for (int j = 0; j <= 20475; j++) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_vec(j)) begin
        errors++;
        if (errors < 30) $display("FAIL wide j=%0d got=%h want=%h", j, obs(), exp_vec(j));
      end
      drive_pixel();
    end
  endtask

  task automatic test_stop_restart();
    start_run(sm_h, sm_v);
    add_frame(sm_h, sm_v, 7);
    for (int j = 0; j <= 104; j++) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_vec(j)) begin
        errors++;
        if (errors < 30) $display("FAIL stop j=%0d got=%h want=%h", j, obs(), exp_vec(j));
      end
      drive_pixel();
      if (j == 31) en = 1'b0;
    end
    en = 1'b1;
    ex.delete();
    pix.delete();
    add_frame(sm_h, sm_v, 7);
    for (int j = 0; j <= 30; j++) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_vec(j)) begin
        errors++;
        if (errors < 30) $display("FAIL restart j=%0d got=%h want=%h", j, obs(), exp_vec(j));
      end
      drive_pixel();
    end
  endtask

  task automatic test_stop_at_end();
    start_run(sm_h, sm_v);
    add_frame(sm_h, sm_v, 7);
    for (int j = 0; j <= 104; j++) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_vec(j)) begin
        errors++;
        if (errors < 30) $display("FAIL stop_end j=%0d got=%h want=%h", j, obs(), exp_vec(j));
      end
      drive_pixel();
      if (j == 97) en = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    start_run(sm_h, sm_v);
    add_frame(sm_h, sm_v, 7);
    add_frame(sm_h, sm_v, 7);
    for (int j = 0; j <= 196; j++) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_vec(j)) begin
        errors++;
        if (errors < 30) $display("FAIL b2b j=%0d got=%h want=%h", j, obs(), exp_vec(j));
      end
      drive_pixel();
      if (j == 20) en = 1'b0;
      if (j == 26) en = 1'b1;
    end
  endtask

  task automatic test_mode_err();
    start_run(sm_h, sm_v);
    add_frame(sm_h, sm_v, 7);
    add_frame(sm_h, sm_v, 7);
    add_frame(sm_h, sm_v, 7);
    err_lo = 98;
    err_hi = 196;
    for (int j = 0; j <= 294; j++) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_vec(j)) begin
        errors++;
        if (errors < 30) $display("FAIL mode_err j=%0d got=%h want=%h", j, obs(), exp_vec(j));
      end
      if (j == 150) begin
        checks++;
        if (width !== 12'd8) begin
          errors++;
          $display("FAIL err_keeps_width got=%0d want=8", width);
        end
      end
      drive_pixel();
      if (j == 30) hw = 12'd15;
      if (j == 118) hw = 12'd8;
    end
  endtask

  task automatic test_invalid_start();
    m_t bad = '{15, 10, 12, 14};
    do_reset();
    set_mode(bad, sm_v);
    en = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({err, rd, nl, nf} !== 4'b1000) begin
      errors++;
      $display("FAIL invalid_start got=%b want=1000", {err, rd, nl, nf});
    end
    set_mode(sm_h, sm_v);
    @(negedge clk);
    checks++;
    if ({err, nl, nf} !== 3'b011) begin
      errors++;
      $display("FAIL valid_after_bad got=%b want=011", {err, nl, nf});
    end
  endtask

  task automatic test_random_modes();
    for (int k = 0; k < 4; k++) begin
      m_t ha = rnd_mode(6);
      m_t va = rnd_mode(4);
      m_t hb = rnd_mode(6);
      m_t vb = rnd_mode(4);
      int tot;
      start_run(ha, va);
      add_frame(ha, va, va.r);
      add_frame(hb, vb, vb.r);
      tot = ex.size();
      for (int j = 0; j <= tot; j++) begin
        @(negedge clk);
        checks++;
        if (obs() !== exp_vec(j)) begin
          errors++;
          if (errors < 30) $display("FAIL random k=%0d j=%0d got=%h want=%h", k, j, obs(), exp_vec(j));
        end
        drive_pixel();
        if (j == 5) set_mode(hb, vb);
      end
      checks++;
      if (width !== 12'(hb.w) || height !== 12'(vb.w)) begin
        errors++;
        $display("FAIL random_relatch got=%0d/%0d want=%0d/%0d", width, height, hb.w, vb.w);
      end
    end
  endtask

  task automatic test_async_reset();
    start_run(sm_h, sm_v);
    add_frame(sm_h, sm_v, 7);
    for (int j = 0; j <= 20; j++) begin
      @(negedge clk);
      checks++;
      if (obs() !== exp_vec(j)) begin
        errors++;
        if (errors < 30) $display("FAIL pre_reset j=%0d got=%h want=%h", j, obs(), exp_vec(j));
      end
      drive_pixel();
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({rd, nl, nf, err, hsync, vsync} !== 6'b000011) begin
      errors++;
      $display("FAIL async_reset_ctl got=%b want=000011", {rd, nl, nf, err, hsync, vsync});
    end
    checks++;
    if ({r, g, b, width, height} !== 36'h0) begin
      errors++;
      $display("FAIL async_reset_data got=%h want=0", {r, g, b, width, height});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({nl, nf, rd} !== 3'b110) begin
      errors++;
      $display("FAIL restart_after_reset got=%b want=110", {nl, nf, rd});
    end
  endtask

  initial begin
    test_reset();
    test_small_raster();
    test_vga640();
    test_wide();
    test_stop_restart();
    test_stop_at_end();
    test_back_to_back();
    test_mode_err();
    test_invalid_start();
    test_random_modes();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
